// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the funct3 legality helper used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    RESP    = 3'd4
  } lsu_state_e;

  // Stores only come in B/H/W flavours; loads additionally have BU/HU.
  function automatic logic funct3_illegal(input logic is_store, input logic [2:0] f3);
    logic legal;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!is_store) begin
      legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return !legal;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic for sub-word accesses: load extraction/extension, store merge
// into a previously read word, and the natural-alignment check.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] store_data,
  output logic [31:0] load_val,
  output logic [31:0] merged,
  output logic        misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed lane of the read word and extend it to 32 bits.
  always_comb begin
    sel_byte = rdata[{addr_lo, 3'b000} +: 8];
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    load_val = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   load_val = {24'h0, sel_byte};
      F3_H:    load_val = {{16{sel_half[15]}}, sel_half};
      F3_HU:   load_val = {16'h0, sel_half};
      F3_W:    load_val = rdata;
      default: load_val = 32'h0;
    endcase
  end

  // Halves need an even address, words a multiple of four.
  always_comb begin
    case (funct3)
      F3_H, F3_HU: misaligned = addr_lo[0];
      F3_W:        misaligned = (addr_lo != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  end

  // Each byte lane either takes new store data or keeps what memory held.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;

      // Decide whether this lane is overwritten and from which store byte.
      always_comb begin
        lane_hit = 1'b0;
        lane_src = store_data[8*gi +: 8];
        case (funct3[1:0])
          2'b00: begin
            lane_hit = (addr_lo == 2'(gi));
            lane_src = store_data[7:0];
          end
          2'b01: begin
            lane_hit = (addr_lo[1] == 1'(gi / 2));
            lane_src = store_data[8*(gi % 2) +: 8];
          end
          default: lane_hit = 1'b1;
        endcase
      end

      assign merged[8*gi +: 8] = lane_hit ? lane_src : rdata[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns RV32I byte/half/word requests into whole-word
// memory reads and writes, using read-modify-write for SB/SH.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) << 2;

  lsu_state_e  state_q;
  logic [2:0]  funct3_q;
  logic        is_store_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] store_data_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] load_data_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic [31:0] al_load;
  logic [31:0] al_merged;
  logic        al_misaligned;
  logic        req_bad;

  // In IDLE the aligner judges the incoming request; later it serves the latched one.
  always_comb begin
    if (state_q == IDLE) begin
      al_funct3  = funct3;
      al_addr_lo = addr[1:0];
    end else begin
      al_funct3  = funct3_q;
      al_addr_lo = addr_lo_q;
    end
  end

  lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .rdata      (mem_rdata),
    .store_data (store_data_q),
    .load_val   (al_load),
    .merged     (al_merged),
    .misaligned (al_misaligned)
  );

  assign req_bad = funct3_illegal(is_store, funct3) | al_misaligned
                 | ({1'b0, addr} >= ADDR_LIMIT);

  // Request sequencer with all handshake and memory-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      funct3_q     <= 3'b000;
      is_store_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      store_data_q <= 32'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      load_data_q  <= 32'h0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            funct3_q     <= funct3;
            is_store_q   <= is_store;
            addr_lo_q    <= addr[1:0];
            store_data_q <= store_data;
            mem_addr_q   <= {2'b00, addr[31:2]};
            load_data_q  <= 32'h0;
            busy_q       <= 1'b1;
            if (req_bad) begin
              state_q <= RESP;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (is_store && (funct3 == F3_W)) begin
              mem_wdata_q <= store_data;
              state_q     <= WRITE;
            end else begin
              state_q <= READ;
            end
          end
        end
        READ: state_q <= CAPTURE;
        CAPTURE: begin
          if (is_store_q) begin
            mem_wdata_q <= al_merged;
            state_q     <= WRITE;
          end else begin
            load_data_q <= al_load;
            state_q     <= RESP;
            done_q      <= 1'b1;
          end
        end
        WRITE: begin
          state_q <= RESP;
          done_q  <= 1'b1;
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en = (state_q == READ);
  assign mem_wr_en = (state_q == WRITE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign load_data = load_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with an attached word memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        busy, done, err, mem_wr_en, mem_rd_en;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_init = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wr_en  (mem_wr_en),
    .mem_rd_en  (mem_rd_en),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    if (i < 8) return 32'(i);
    if (i < 16) return 32'(16 + i - 8);
    return 32'h0;
  endfunction

  // Data memory: registered read, write on wr_en.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
    end else begin
      if (mem_wr_en) mem[mem_addr[9:0]] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= mem[mem_addr[9:0]];
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    return w[8*int'(a[1:0]) +: 8];
  endfunction

  // Reference model: byte-addressed memory view, plain arithmetic.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output logic e, output logic [31:0] ld,
                       output int lat, output int rds, output int wrs);
    int size;
    logic legal;
    logic [31:0] val, w, ab;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << int'(f3[1:0]);
    e     = !legal || ((a % 32'(size)) != 0) || (a >= 32'd4096);
    ld = 32'h0; lat = 1; rds = 0; wrs = 0;
    if (e) return;
    if (!st) begin
      val = 32'h0;
      for (int k = 0; k < size; k++) val = val | (32'(ref_byte(a + 32'(k))) << (8 * k));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'h1 << (8 * size)) - 32'h1);
      ld = val; lat = 3; rds = 1;
    end else begin
      for (int k = 0; k < size; k++) begin
        ab = a + 32'(k);
        w = ref_mem[ab[11:2]];
        w[8*int'(ab[1:0]) +: 8] = d[8*k +: 8];
        ref_mem[ab[11:2]] = w;
      end
      lat = (size == 4) ? 2 : 4;
      rds = (size == 4) ? 0 : 1;
      wrs = 1;
    end
  endtask

  // Issue one request and observe it until done (bounded).
  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, output logic e, output logic [31:0] ld,
                        output int lat, output int rds, output int wrs,
                        output logic [31:0] rd_addr, output logic [31:0] wdata);
    @(negedge clk);
    is_store = st; funct3 = f3; addr = a; store_data = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; rds = 0; wrs = 0; e = 1'b0; ld = 32'h0; rd_addr = 32'h0; wdata = 32'h0;
    for (int n = 0; n < 20; n++) begin
      if (mem_rd_en) begin rds++; rd_addr = mem_addr; end
      if (mem_wr_en) begin wrs++; wdata = mem_wdata; end
      if (done) begin e = err; ld = load_data; break; end
      lat++;
      @(negedge clk);
    end
    if (!done) lat = -1;
  endtask

  task automatic check_req(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic got_e, output logic [31:0] got_ld);
    logic ee;
    logic [31:0] eld, rda, wd, exp_w;
    int el, er, ew, gl, gr, gw;
    model(st, f3, a, d, ee, eld, el, er, ew);
    exp_w = ref_mem[a[11:2]];
    do_req(st, f3, a, d, got_e, got_ld, gl, gr, gw, rda, wd);
    $display("txn %s st=%0d f3=%0d addr=%08h data=%08h -> err=%0d load=%08h lat=%0d rd=%0d wr=%0d",
             tag, st, f3, a, d, got_e, got_ld, gl, gr, gw);
    chk({tag, " err"}, 32'(got_e), 32'(ee));
    chk({tag, " latency"}, 32'(gl), 32'(el));
    chk({tag, " rd_en cycles"}, 32'(gr), 32'(er));
    chk({tag, " wr_en cycles"}, 32'(gw), 32'(ew));
    if (!st || ee) chk({tag, " load_data"}, got_ld, eld);
    if (er != 0) chk({tag, " rd mem_addr"}, rda, {2'b00, a[31:2]});
    if (ew != 0) chk({tag, " mem_wdata"}, wd, exp_w);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    logic [31:0] exp_ld;
  } vec_t;

  vec_t tbl [12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ge;
    logic [31:0] gld;
    int dones, rds, wrs;
    logic [31:0] busy_ld, rda;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

    tbl[0]  = '{1'b0, 3'b010, 32'h0000000C, 32'h0,        1'b0, 32'h00000003};
    tbl[1]  = '{1'b1, 3'b010, 32'h00000010, 32'h8081FF7F, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 3'b000, 32'h00000011, 32'h0,        1'b0, 32'hFFFFFFFF};
    tbl[3]  = '{1'b0, 3'b100, 32'h00000013, 32'h0,        1'b0, 32'h00000080};
    tbl[4]  = '{1'b0, 3'b001, 32'h00000012, 32'h0,        1'b0, 32'hFFFF8081};
    tbl[5]  = '{1'b0, 3'b101, 32'h00000010, 32'h0,        1'b0, 32'h0000FF7F};
    tbl[6]  = '{1'b1, 3'b000, 32'h00000015, 32'h123456AB, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 3'b010, 32'h00000014, 32'h0,        1'b0, 32'h0000AB05};
    tbl[8]  = '{1'b0, 3'b010, 32'h00000006, 32'h0,        1'b1, 32'h0};
    tbl[9]  = '{1'b1, 3'b001, 32'h00000021, 32'h0,        1'b1, 32'h0};
    tbl[10] = '{1'b0, 3'b010, 32'h00001000, 32'h0,        1'b1, 32'h0};
    tbl[11] = '{1'b0, 3'b011, 32'h00000000, 32'h0,        1'b1, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset err", 32'(err), 32'h0);
    chk("reset load_data", load_data, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset mem_wr_en", 32'(mem_wr_en), 32'h0);
    chk("reset mem_rd_en", 32'(mem_rd_en), 32'h0);
    rst = 1'b0;
    mem_init = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      check_req($sformatf("vec%0d", i), tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].d, ge, gld);
      chk($sformatf("vec%0d table err", i), 32'(ge), 32'(tbl[i].exp_err));
      if (!tbl[i].st || tbl[i].exp_err) chk($sformatf("vec%0d table load", i), gld, tbl[i].exp_ld);
    end

    // Reset during CAPTURE abandons the SH
    wrs = 0;
    @(negedge clk);
    is_store = 1'b1; funct3 = 3'b001; addr = 32'h1C; store_data = 32'h0000BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mem_wr_en) wrs++;
    @(negedge clk);
    if (mem_wr_en) wrs++;
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy after edge", 32'(busy), 32'h0);
    chk("rst done after edge", 32'(done), 32'h0);
    if (mem_wr_en) wrs++;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (mem_wr_en) wrs++;
    end
    $display("txn rst_in_capture SH addr=0000001c wr=%0d word7=%08h", wrs, mem[7]);
    chk("rst wr_en cycles", 32'(wrs), 32'h0);
    chk("rst word7 untouched", mem[7], 32'h00000007);

    // Start while busy and in RESP is ignored
    dones = 0; rds = 0; busy_ld = 32'h0; rda = 32'h0;
    @(negedge clk);
    is_store = 1'b0; funct3 = 3'b010; addr = 32'h0C; start = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) addr = 32'h08;
      if (n >= 4) start = 1'b0;
      if (mem_rd_en) begin rds++; rda = mem_addr; end
      if (done) begin dones++; busy_ld = load_data; end
    end
    start = 1'b0;
    $display("txn busy_start LW addr=0000000c dones=%0d rd=%0d load=%08h", dones, rds, busy_ld);
    chk("busy start dones", 32'(dones), 32'd1);
    chk("busy start rd_en cycles", 32'(rds), 32'd1);
    chk("busy start rd addr", rda, 32'd3);
    chk("busy start load_data", busy_ld, 32'h00000003);

    // Back-to-back: second request issued in the first IDLE cycle after RESP
    check_req("b2b_a", 1'b0, 3'b010, 32'h08, 32'h0, ge, gld);
    check_req("b2b_b", 1'b0, 3'b000, 32'h0C, 32'h0, ge, gld);

    // Randomized requests against the model
    for (int i = 0; i < 300; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      int          r;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      r  = int'($urandom_range(0, 9));
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'd4092 + 32'($urandom_range(0, 7));
      else a = 32'($urandom_range(0, 63));
      check_req($sformatf("rnd%0d", i), st, f3, a, $urandom, ge, gld);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
